// File: rtl/cache.sv
// ---------------------------------------------------------------------------
// cache
//   Two-way set-associative, write-allocate data cache with per-set LRU
//   replacement, in front of a 2^ADDR_W-byte word-organised main memory that
//   lives inside this block. Every strobed request completes on the edge that
//   samples it; the response is registered and visible in the next cycle.
//
//   Build option: define CACHE_WRITE_THROUGH_EN to make every write also
//   update main memory immediately (no dirty lines, no write-back). Without
//   it the cache is write-back.
//
// Ports
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset
//   req_valid_from_cpu   in   request strobe, one access per cycle it is high
//   read_write_from_cpu  in   0 = read, 1 = write
//   address_from_cpu     in   byte address, bits [1:0] ignored
//   write_data_from_cpu  in   write data
//   read_data_out        out  accessed word (write data on writes)
//   hit_miss_out         out  1 = hit, 0 = miss
//   resp_valid_out       out  one-cycle pulse marking a valid response
// ---------------------------------------------------------------------------
module cache #(
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_from_cpu,
  input  logic              read_write_from_cpu,
  input  logic [ADDR_W-1:0] address_from_cpu,
  input  logic [31:0]       write_data_from_cpu,
  output logic [31:0]       read_data_out,
  output logic              hit_miss_out,
  output logic              resp_valid_out
);

  localparam int OFF_W     = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int MEM_AW    = ADDR_W - 2;
  localparam int TAG_W     = MEM_AW - OFF_W - IDX_W;
  localparam int MEM_WORDS = 1 << MEM_AW;

`ifdef CACHE_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  // ---------------- state ----------------
  logic             valid_q [NUM_SETS][2];
  logic             dirty_q [NUM_SETS][2];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][2];
  logic [31:0]      data_q  [NUM_SETS][2][WORDS_PER_BLOCK];
  logic             lru_q   [NUM_SETS];   // way that is least recently used
  logic [31:0]      mem_q   [MEM_WORDS];

  logic [31:0]      rdata_q;
  logic             hit_q;
  logic             resp_q;

  // ---------------- address decode ----------------
  logic [MEM_AW-1:0] word_addr;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              unused_byte_bits;

  assign word_addr        = address_from_cpu[ADDR_W-1:2];
  assign off              = word_addr[OFF_W-1:0];
  assign idx              = word_addr[OFF_W +: IDX_W];
  assign tag              = word_addr[MEM_AW-1 -: TAG_W];
  assign unused_byte_bits = ^address_from_cpu[1:0];

  // ---------------- lookup and replacement ----------------
  logic              hit_way0, hit_way1, hit;
  logic              victim_way, acc_way;
  logic              wb_en;
  logic              dirty_d;
  logic [MEM_AW-1:0] refill_base, wb_base;
  logic [31:0]       fill_word [WORDS_PER_BLOCK];
  logic [31:0]       line_d    [WORDS_PER_BLOCK];
  logic [31:0]       rdata_d;

  assign hit_way0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit_way1 = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hit      = hit_way0 | hit_way1;

  // Empty ways are filled before anything is evicted; way 0 first.
  assign victim_way = !valid_q[idx][0] ? 1'b0 :
                      !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign acc_way    = hit ? hit_way1 : victim_way;

  assign wb_en = !WRITE_THROUGH && !hit &&
                 valid_q[idx][victim_way] && dirty_q[idx][victim_way];

  assign refill_base = {tag, idx, OFF_W'(0)};
  assign wb_base     = {tag_q[idx][victim_way], idx, OFF_W'(0)};

  // A line stays dirty if it already was and is hit; any write dirties it.
  assign dirty_d = !WRITE_THROUGH &&
                   (read_write_from_cpu || (hit && dirty_q[idx][acc_way]));

  // New line contents: existing line on a hit, memory block on a miss, with
  // the write word merged in. The write-back of the same edge is forwarded
  // into the refill so the refill always observes memory after write-back.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_line
      assign fill_word[gi] = (wb_en && (wb_base == refill_base)) ?
                             data_q[idx][victim_way][gi] :
                             mem_q[refill_base | MEM_AW'(gi)];
      assign line_d[gi] = (read_write_from_cpu && (off == OFF_W'(gi))) ?
                          write_data_from_cpu :
                          (hit ? data_q[idx][acc_way][gi] : fill_word[gi]);
    end
  endgenerate

  assign rdata_d = line_d[off];

  // ---------------- state update ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            data_q[s][w][k] <= '0;
          end
        end
      end
      for (int m = 0; m < MEM_WORDS; m++) begin
        mem_q[m] <= 32'(m);
      end
      rdata_q <= '0;
      hit_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= req_valid_from_cpu;
      if (req_valid_from_cpu) begin
        if (wb_en) begin
          for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            mem_q[wb_base + MEM_AW'(k)] <= data_q[idx][victim_way][k];
          end
        end
        if (WRITE_THROUGH && read_write_from_cpu) begin
          mem_q[word_addr] <= write_data_from_cpu;
        end
        valid_q[idx][acc_way] <= 1'b1;
        dirty_q[idx][acc_way] <= dirty_d;
        tag_q[idx][acc_way]   <= tag;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
          data_q[idx][acc_way][k] <= line_d[k];
        end
        lru_q[idx] <= ~acc_way;
        rdata_q    <= rdata_d;
        hit_q      <= hit;
      end
    end
  end

  assign read_data_out  = rdata_q;
  assign hit_miss_out   = hit_q;
  assign resp_valid_out = resp_q;

endmodule

// File: tb/tb_cache.sv
// ---------------------------------------------------------------------------
// tb_cache
//   Self-checking bench for cache: directed sequence, idle cycles, mid-stream
//   reset and a randomized access stream, all compared against a block-level
//   reference model of memory plus a two-way LRU cache.
// ---------------------------------------------------------------------------
module tb_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        rw;
  logic [9:0]  addr;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        hit;
  logic        resp;

  always #5 clk = ~clk;

  cache dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_from_cpu  (req),
    .read_write_from_cpu (rw),
    .address_from_cpu    (addr),
    .write_data_from_cpu (wd),
    .read_data_out       (rdata),
    .hit_miss_out        (hit),
    .resp_valid_out      (resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [256];
  logic [31:0] dat_m [2][2][4];
  int          tag_m [2][2];
  bit          v_m   [2][2];
  bit          d_m   [2][2];
  bit          lru_m [2];

  logic [31:0] last_data;
  logic        last_hit;

  task automatic model_reset();
    for (int w = 0; w < 256; w++) mem_m[w] = 32'(w);
    for (int s = 0; s < 2; s++) begin
      lru_m[s] = 0;
      for (int w = 0; w < 2; w++) begin
        v_m[s][w] = 0;
        d_m[s][w] = 0;
        tag_m[s][w] = 0;
      end
    end
    last_data = '0;
    last_hit  = 1'b0;
  endtask

  task automatic model_access(input bit w, input logic [9:0] a, input logic [31:0] d,
                              output logic [31:0] ed, output bit eh);
    int blk, set, tg, off, way;
    blk = int'(a) / 16;
    set = blk % 2;
    tg  = blk / 2;
    off = (int'(a) / 4) % 4;
    way = -1;
    for (int i = 0; i < 2; i++)
      if (v_m[set][i] && tag_m[set][i] == tg) way = i;
    eh = (way >= 0);
    if (!eh) begin
      if (!v_m[set][0]) way = 0;
      else if (!v_m[set][1]) way = 1;
      else way = int'(lru_m[set]);
      if (v_m[set][way] && d_m[set][way])
        for (int k = 0; k < 4; k++)
          mem_m[(tag_m[set][way] * 2 + set) * 4 + k] = dat_m[set][way][k];
      for (int k = 0; k < 4; k++) dat_m[set][way][k] = mem_m[blk * 4 + k];
      v_m[set][way]   = 1;
      d_m[set][way]   = 0;
      tag_m[set][way] = tg;
    end
    if (w) begin
      dat_m[set][way][off] = d;
`ifdef CACHE_WRITE_THROUGH_EN
      mem_m[int'(a) / 4] = d;
`else
      d_m[set][way] = 1;
`endif
    end
    ed = dat_m[set][way][off];
    lru_m[set] = (way == 0);
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic do_req(input bit w, input logic [9:0] a, input logic [31:0] d,
                        output logic [31:0] got_d, output logic got_h);
    logic [31:0] ed;
    bit          eh;
    @(negedge clk);
    req  = 1'b1;
    rw   = w;
    addr = a;
    wd   = d;
    model_access(w, a, d, ed, eh);
    @(posedge clk);
    #1;
    check("resp_valid", {31'b0, resp}, 32'd1);
    check("hit", {31'b0, hit}, {31'b0, eh});
    check("data", rdata, ed);
    got_d     = rdata;
    got_h     = hit;
    last_data = ed;
    last_hit  = eh;
    $display("txn %s addr=%h wdata=%h -> hit=%0d data=%h (model hit=%0d data=%h)",
             w ? "WR" : "RD", a, d, hit, rdata, eh, ed);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req  = 1'b0;
    rw   = $urandom_range(0, 1);
    addr = 10'($urandom);
    wd   = $urandom;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_resp", {31'b0, resp}, 32'd0);
      check("idle_hit_hold", {31'b0, hit}, {31'b0, last_hit});
      check("idle_data_hold", rdata, last_data);
      $display("txn IDLE -> resp=%0d hit=%0d data=%h", resp, hit, rdata);
    end
  endtask

  logic [31:0] gd;
  logic        gh;
  logic [9:0]  ra;

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wd    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp", {31'b0, resp}, 32'd0);
    check("reset_hit", {31'b0, hit}, 32'd0);
    check("reset_data", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence
    do_req(0, 10'h000, 32'h0, gd, gh);
    check("t_rd0_hit", {31'b0, gh}, 32'd0);
    check("t_rd0_data", gd, 32'h0000_0000);
    do_req(1, 10'h000, 32'h0000_00FF, gd, gh);
    check("t_wr0_hit", {31'b0, gh}, 32'd1);
    check("t_wr0_data", gd, 32'h0000_00FF);
    do_req(0, 10'h000, 32'h0, gd, gh);
    check("t_rd0b_data", gd, 32'h0000_00FF);
    do_req(0, 10'h200, 32'h0, gd, gh);
    check("t_rd200_hit", {31'b0, gh}, 32'd0);
    check("t_rd200_data", gd, 32'h0000_0080);
    do_req(0, 10'h000, 32'h0, gd, gh);
    check("t_rd0c_hit", {31'b0, gh}, 32'd1);
    do_req(0, 10'h300, 32'h0, gd, gh);
    check("t_rd300_data", gd, 32'h0000_00C0);
    do_req(0, 10'h200, 32'h0, gd, gh);
    check("t_rd200b_hit", {31'b0, gh}, 32'd0);
    do_req(0, 10'h000, 32'h0, gd, gh);
    check("t_wb_data", gd, 32'h0000_00FF);
    do_req(0, 10'h004, 32'h0, gd, gh);
    check("t_rd004_hit", {31'b0, gh}, 32'd1);
    check("t_rd004_data", gd, 32'h0000_0001);
    idle(3);

    // Randomized stream, mostly confined to a few tags to force conflicts
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 7) == 0) ra = 10'($urandom);
      else ra = 10'($urandom_range(0, 3) * 32 + $urandom_range(0, 1) * 16 +
                    $urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), ra, $urandom, gd, gh);
    end

    // Reset while a response is showing
    do_req(1, 10'h000, 32'hDEAD_BEEF, gd, gh);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp", {31'b0, resp}, 32'd0);
    check("midrst_hit", {31'b0, hit}, 32'd0);
    check("midrst_data", rdata, 32'd0);
    req = 1'b1;
    rw  = 1'b1;
    wd  = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("inrst_resp", {31'b0, resp}, 32'd0);
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b1;
    model_reset();
    do_req(0, 10'h000, 32'h0, gd, gh);
    check("post_rst_hit", {31'b0, gh}, 32'd0);
    check("post_rst_data", gd, 32'h0000_0000);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
